// File: rtl/rf_write_arbiter_pkg.sv
// Shared CPU definitions used by the register-file write path.
package rf_write_arbiter_pkg;

  localparam int REG_AW   = 2;
  localparam int REG_DW   = 4;
  localparam int NUM_REGS = 4;

  // Requester identity as remembered by the round-robin arbiter.
  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  // One register-file write: destination and payload.
  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/rf_write_arbiter_rr_arb2.sv
// Two-way round-robin grant with a registered last_grant.
// Grants are combinational; last_grant moves only on an actual grant.
module rr_arb2
  import rf_write_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_id_e last_grant;

  // Pick a winner; on contention favour whoever did not win last.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_grant == REQ_B) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Remember the most recent winner; reset to B so A wins first contention.
  always_ff @(posedge clk) begin
    if (rst)       last_grant <= REQ_B;
    else if (|gnt) last_grant <= gnt[1] ? REQ_B : REQ_A;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write arbiter: merges ALU (A) and load (B) writebacks into
// one write port with a one-cycle registered output, tracks in-flight
// destinations in a pending scoreboard and counts issued writes.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              a_valid,
  input  logic [REG_AW-1:0] a_addr,
  input  logic [REG_DW-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [REG_AW-1:0] b_addr,
  input  logic [REG_DW-1:0] b_data,
  output logic              b_ready,
  output logic              we,
  output logic [REG_AW-1:0] waddr,
  output logic [REG_DW-1:0] wdata,
  output logic [NUM_REGS-1:0] pending,
  output logic [CNT_W-1:0]  wr_count
);

  logic [1:0]          gnt;
  logic                xfer;
  wr_req_t             acc;
  logic [NUM_REGS-1:0] pending_nxt;

  // Stall and reset both block new acceptances; in-flight writes continue.
  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .en  (!stall && !rst),
    .req ({b_valid, a_valid}),
    .gnt (gnt)
  );

  assign a_ready = gnt[0];
  assign b_ready = gnt[1];
  assign xfer    = |gnt;

  // Select the accepted request's payload.
  always_comb begin
    acc = '{addr: a_addr, data: a_data};
    if (gnt[1]) acc = '{addr: b_addr, data: b_data};
  end

  // Output stage: one cycle after acceptance; addr/data hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      we <= xfer;
      if (xfer) begin
        waddr <= acc.addr;
        wdata <= acc.data;
      end
    end
  end

  // Scoreboard next state: commit clears first, so a same-address accept wins.
  always_comb begin
    pending_nxt = pending;
    if (we)   pending_nxt[waddr]    = 1'b0;
    if (xfer) pending_nxt[acc.addr] = 1'b1;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end

  // Saturating count of issued writes.
  always_ff @(posedge clk) begin
    if (rst)                      wr_count <= '0;
    else if (we && ~&wr_count)    wr_count <= wr_count + 1'b1;
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter. Inputs change 1ns after the rising
// edge; outputs are checked on the falling edge.
module tb_rf_write_arbiter;

  logic       clk = 1'b0;
  logic       rst, stall;
  logic       a_valid, b_valid;
  logic [1:0] a_addr, b_addr;
  logic [3:0] a_data, b_data;
  logic       a_ready, b_ready, we;
  logic [1:0] waddr;
  logic [3:0] wdata, pending;
  logic [7:0] wr_count;
  // second instance, narrow counter, same stimulus
  logic       a_ready2, b_ready2, we2;
  logic [1:0] waddr2;
  logic [3:0] wdata2, pending2;
  logic [1:0] wr_count2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rf_write_arbiter #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .we(we), .waddr(waddr), .wdata(wdata), .pending(pending), .wr_count(wr_count)
  );

  rf_write_arbiter #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .stall(stall),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready2),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready2),
    .we(we2), .waddr(waddr2), .wdata(wdata2), .pending(pending2), .wr_count(wr_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic to_drive(); @(posedge clk); #1; endtask
  task automatic to_check(); @(negedge clk); endtask

  task automatic idle_inputs();
    stall = 0; a_valid = 0; b_valid = 0;
    a_addr = 0; a_data = 0; b_addr = 0; b_data = 0;
  endtask

  // Two reset edges, then release; caller is left just after an edge.
  task automatic do_reset();
    idle_inputs();
    rst = 1;
    to_drive();
    to_drive();
    rst = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    a_valid = 1; b_valid = 1; a_addr = 1; b_addr = 2;
    // Reset state and no acceptance while rst high
    to_drive();
    to_check();
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_we", we, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_pending", pending, 0);
    chk("rst_count", wr_count, 0);
    to_drive();
    rst = 0;

    // First contention: A then B
    a_valid = 1; a_addr = 1; a_data = 4'h5;
    b_valid = 1; b_addr = 2; b_data = 4'hA;
    to_check();
    chk("c1_a_ready", a_ready, 1);
    chk("c1_b_ready", b_ready, 0);
    to_drive();
    a_valid = 0;
    to_check();
    chk("c2_b_ready", b_ready, 1);
    chk("c2_we", we, 1);
    chk("c2_waddr", waddr, 1);
    chk("c2_wdata", wdata, 4'h5);
    chk("c2_pending", pending, 4'b0010);
    to_drive();
    b_valid = 0;
    to_check();
    chk("c3_we", we, 1);
    chk("c3_waddr", waddr, 2);
    chk("c3_wdata", wdata, 4'hA);
    chk("c3_pending", pending, 4'b0100);
    chk("c3_count", wr_count, 1);
    to_drive();
    to_check();
    chk("c4_we", we, 0);
    chk("c4_waddr_hold", waddr, 2);
    chk("c4_wdata_hold", wdata, 4'hA);
    chk("c4_pending", pending, 0);
    chk("c4_count", wr_count, 2);

    // Sustained contention: alternating A,B with no bubbles
    do_reset();
    a_valid = 1; a_addr = 0; a_data = 4'h1;
    b_valid = 1; b_addr = 3; b_data = 4'h2;
    for (int i = 0; i < 6; i++) begin
      to_check();
      chk($sformatf("rr%0d_a_ready", i), a_ready, (i % 2 == 0));
      chk($sformatf("rr%0d_b_ready", i), b_ready, (i % 2 == 1));
      if (i > 0) begin
        chk($sformatf("rr%0d_we", i), we, 1);
        chk($sformatf("rr%0d_waddr", i), waddr, (i % 2 == 1) ? 0 : 3);
      end
      to_drive();
    end
    a_valid = 0; b_valid = 0;
    to_check();
    chk("rr_last_we", we, 1);
    chk("rr_last_waddr", waddr, 3);
    to_drive();
    to_check();
    chk("rr_idle_we", we, 0);
    chk("rr_count", wr_count, 6);

    // Scoreboard: single write to R3, then back-to-back writes to R3
    do_reset();
    a_valid = 1; a_addr = 3; a_data = 4'h9;
    to_drive();
    a_valid = 0;
    to_check();
    chk("pd1_set", pending, 4'b1000);
    to_drive();
    to_check();
    chk("pd1_clr", pending, 0);
    a_valid = 1;
    to_drive();
    to_check();
    chk("pd2_set", pending, 4'b1000);
    to_drive();
    a_valid = 0;
    to_check();
    chk("pd2_hold", pending, 4'b1000);
    to_drive();
    to_check();
    chk("pd2_clr", pending, 0);

    // Stall: in-flight write commits, no new acceptance
    do_reset();
    a_valid = 1; a_addr = 2; a_data = 4'h3;
    b_valid = 1; b_addr = 1; b_data = 4'h4;
    to_drive();
    stall = 1;
    to_check();
    chk("st1_a_ready", a_ready, 0);
    chk("st1_b_ready", b_ready, 0);
    chk("st1_we", we, 1);
    chk("st1_waddr", waddr, 2);
    to_drive();
    to_check();
    chk("st2_we", we, 0);
    chk("st2_count", wr_count, 1);
    chk("st2_ready", {a_ready, b_ready}, 0);
    to_drive();
    to_check();
    chk("st3_we", we, 0);
    to_drive();
    stall = 0;
    to_check();
    chk("st_rel_b_ready", b_ready, 1);
    chk("st_rel_a_ready", a_ready, 0);

    // Narrow counter saturation
    do_reset();
    a_valid = 1; a_addr = 0; a_data = 4'h6;
    to_drive();
    for (int i = 0; i < 5; i++) begin
      if (i == 4) a_valid = 0;
      to_drive();
      to_check();
      chk($sformatf("sat%0d_count", i), wr_count2, (i < 3) ? i + 1 : 3);
    end
    chk("sat_wide_count", wr_count, 5);

    // Reset right after a transfer to R0 discards it
    do_reset();
    a_valid = 1; a_addr = 0; a_data = 4'h7;
    to_drive();
    a_valid = 0;
    rst = 1;
    to_check();
    chk("rr0_we_inflight", we, 1);
    chk("rr0_pending", pending, 4'b0001);
    chk("rr0_ready_in_rst", a_ready, 0);
    to_drive();
    rst = 0;
    to_check();
    chk("rr0_we", we, 0);
    chk("rr0_pending_clr", pending, 0);
    chk("rr0_count", wr_count, 0);
    a_valid = 1; b_valid = 1; a_addr = 1; b_addr = 2;
    #1;
    chk("rr0_a_first", a_ready, 1);
    chk("rr0_b_wait", b_ready, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter CNT_W, default 8: width of the write-event counter.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 stall  input  1  when high, the block accepts no request.
REQ-005 a_valid  input  1  requester A (ALU writeback) has a write pending.
REQ-006 a_addr  input  2  requester A destination register.
REQ-007 a_data  input  4  requester A write data.
REQ-008 a_ready  output  1  requester A handshake completes this cycle.
REQ-009 b_valid, b_addr[1:0], b_data[3:0], b_ready: same as REQ-005..008 for requester B (load unit).
REQ-010 we  output  1  register-file write enable.
REQ-011 waddr  output  2  register-file write address.
REQ-012 wdata  output  4  register-file write data.
REQ-013 pending  output  4  per-register scoreboard; bit i high means a write to Ri is accepted but not yet committed.
REQ-014 wr_count  output  CNT_W  number of register-file writes issued, saturating.

Function
REQ-015 Handshake: a transfer occurs on X when x_valid and x_ready are both high at a rising edge; a requester holds valid, addr and data stable until it is accepted.
REQ-016 a_ready and b_ready are combinational; at most one is high in any cycle; both are low while stall or rst is high.
REQ-017 Only A valid -> grant A; only B valid -> grant B; neither valid -> no grant.
REQ-018 Both valid -> grant the requester not recorded in last_grant (round-robin).
REQ-019 last_grant updates to the granted requester on every transfer and is unchanged otherwise.
REQ-020 Output latency is 1 cycle: for a transfer at edge N, we=1 with the accepted addr/data during cycle N+1; the register file commits at edge N+1.
REQ-021 No transfer at edge N -> we=0 during cycle N+1; waddr/wdata hold their previous values.
REQ-022 Throughput: one transfer per cycle is sustained, with no bubbles.
REQ-023 pending[addr] sets at the transfer edge and clears at the commit edge (the edge where we=1 with that waddr).
REQ-024 If a new transfer to the same address coincides with a commit, the set wins and pending stays high.
REQ-025 The block performs no hazard stalling; pending is advisory for an upstream issue stage.
REQ-026 wr_count increments by 1 at each edge where we=1 and holds at 2^CNT_W-1 (no wrap).
REQ-027 If stall rises while we=1, the in-flight write still commits; stall blocks only new transfers.

Reset
REQ-028 At a rst edge: we=0, waddr=0, wdata=0, pending=0, wr_count=0, and last_grant=B so A wins the first contention.
REQ-029 Reset mid-operation discards any accepted-but-uncommitted write; we=0 in the cycle after the reset edge.
REQ-030 While rst is high, no transfer occurs regardless of valid inputs.

Structure
REQ-031 The shared CPU package holds REG_AW=2, REG_DW=4, NUM_REGS=4 and the requester-ID encoding (REQ_A=0, REQ_B=1).
REQ-032 One sub-module, rr_arb2 (a 2-way round-robin grant with a last_grant register), is instantiated once.
REQ-033 The scoreboard and wr_count live in the top module.

Verification
REQ-034 After reset, A (addr 1, data 0x5) and B (addr 2, data 0xA) both valid -> A granted first, then B; we pulses with (1,0x5) then (2,0xA) on consecutive cycles.
REQ-035 A and B held valid continuously for 6 cycles -> grants alternate A,B,A,B,A,B; wr_count=6; no idle cycle with we=0 between them.
REQ-036 A writes R3 at edge N -> pending=4'b1000 during cycle N+1; pending=0 after edge N+1 unless R3 is re-accepted at edge N+1, in which case bit 3 stays set.
REQ-037 stall=1 for 3 cycles with both valid -> both ready low, we=0 from the second stall cycle on, and the in-flight write still commits.
REQ-038 CNT_W=2 with 5 writes -> wr_count reads 1,2,3,3,3.
REQ-039 rst asserted the cycle after a transfer to R0 -> we=0 next cycle, pending=0, wr_count=0, and a subsequent A/B contention grants A.
